// File: rtl/decode_stage_pkg.sv
// Shared constants and types for the MIPS32 decode stage.
package decode_stage_pkg;

    localparam int WORD_LEN    = 32;
    localparam int OPCODE_LEN  = 6;
    localparam int REGADDR_LEN = 5;

    // Opcodes that steer instruction class and immediate extension.
    localparam logic [OPCODE_LEN-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_LEN-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_LEN-1:0] OP_JAL   = 6'h03;
    localparam logic [OPCODE_LEN-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_LEN-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_LEN-1:0] OP_XORI  = 6'h0E;
    localparam logic [OPCODE_LEN-1:0] OP_LUI   = 6'h0F;

    // Instruction class codes; the value 3 is never produced.
    typedef enum logic [1:0] {
        CLASS_R = 2'd0,
        CLASS_I = 2'd1,
        CLASS_J = 2'd2
    } inst_class_e;

    // Classify an instruction by its opcode; unknown opcodes are I-type.
    function automatic inst_class_e classify(input logic [OPCODE_LEN-1:0] op);
        if (op == OP_RTYPE) begin
            return CLASS_R;
        end else if (op == OP_J || op == OP_JAL) begin
            return CLASS_J;
        end else begin
            return CLASS_I;
        end
    endfunction

endpackage

// File: rtl/decode_stage_fields.sv
// Combinational field splitter: instruction word -> fields, class, extended immediate.
module decode_fields
    import decode_stage_pkg::*;
#(
    parameter int EXT_W = 32
) (
    input  logic [WORD_LEN-1:0]    Inst,
    output logic [OPCODE_LEN-1:0]  OpCode,
    output logic [REGADDR_LEN-1:0] Rs,
    output logic [REGADDR_LEN-1:0] Rt,
    output logic [REGADDR_LEN-1:0] Rd,
    output logic [4:0]             Shamt,
    output logic [5:0]             Funct,
    output logic [25:0]            Addr,
    output logic [15:0]            Imm,
    output logic [EXT_W-1:0]       ExtImm,
    output logic [1:0]             InstClass
);

    logic [31:0] lui_word;

    assign OpCode    = Inst[31:26];
    assign Rs        = Inst[25:21];
    assign Rt        = Inst[20:16];
    assign Rd        = Inst[15:11];
    assign Shamt     = Inst[10:6];
    assign Funct     = Inst[5:0];
    assign Addr      = Inst[25:0];
    assign Imm       = Inst[15:0];
    assign InstClass = classify(Inst[31:26]);
    assign lui_word  = {Inst[15:0], 16'h0000};

    // Pick the immediate extension mode from the opcode.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        ExtImm = EXT_W'($signed(Inst[15:0]));
        case (Inst[31:26])
            OP_ANDI, OP_ORI, OP_XORI: ExtImm = EXT_W'(Inst[15:0]);
            OP_LUI:                   ExtImm = EXT_W'(lui_word);
            default:                  ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered MIPS32 decode stage: 2-entry skid buffer in front of a field decoder.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int W     = WORD_LEN,
    parameter int PC_W  = 32,
    parameter int EXT_W = 32
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Flush,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [PC_W-1:0]        InPC,
    input  logic [W-1:0]           Inst,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [PC_W-1:0]        OutPC,
    output logic [OPCODE_LEN-1:0]  OpCode,
    output logic [REGADDR_LEN-1:0] Rs,
    output logic [REGADDR_LEN-1:0] Rt,
    output logic [REGADDR_LEN-1:0] Rd,
    output logic [4:0]             Shamt,
    output logic [5:0]             Funct,
    output logic [25:0]            Addr,
    output logic [15:0]            Imm,
    output logic [EXT_W-1:0]       ExtImm,
    output logic [1:0]             InstClass
);

    // Main slot (drives the outputs) and skid slot (absorbs one extra word).
    logic            m_valid_q, m_valid_d;
    logic [PC_W-1:0] m_pc_q,    m_pc_d;
    logic [W-1:0]    m_inst_q,  m_inst_d;
    logic            s_valid_q, s_valid_d;
    logic [PC_W-1:0] s_pc_q,    s_pc_d;
    logic [W-1:0]    s_inst_q,  s_inst_d;

    logic accept;
    logic pop;

    // Ready depends only on registered state, never on OutReady.
    assign InReady  = !s_valid_q;
    assign OutValid = m_valid_q;
    assign OutPC    = m_pc_q;
    assign accept   = InValid && InReady;
    assign pop      = m_valid_q && OutReady;

    // Slot update rules; payload changes only when a slot is written.
    always_comb begin
        m_valid_d = m_valid_q;
        m_pc_d    = m_pc_q;
        m_inst_d  = m_inst_q;
        s_valid_d = s_valid_q;
        s_pc_d    = s_pc_q;
        s_inst_d  = s_inst_q;

        if (Flush) begin
            // Redirect drops everything, including a word offered this cycle.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (pop) begin
            if (s_valid_q) begin
                // InReady is low here, so no accept can coincide.
                m_valid_d = 1'b1;
                m_pc_d    = s_pc_q;
                m_inst_d  = s_inst_q;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_valid_d = 1'b1;
                m_pc_d    = InPC;
                m_inst_d  = Inst;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!m_valid_q) begin
                m_valid_d = 1'b1;
                m_pc_d    = InPC;
                m_inst_d  = Inst;
            end else begin
                s_valid_d = 1'b1;
                s_pc_d    = InPC;
                s_inst_d  = Inst;
            end
        end
    end

    // State registers with synchronous reset that also clears the payload.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (Rst) begin
            // NOTE: payload storage is zeroed too, so post-reset fields read as all-zero.
            m_valid_q <= 1'b0;
            m_pc_q    <= '0;
            m_inst_q  <= '0;
            s_valid_q <= 1'b0;
            s_pc_q    <= '0;
            s_inst_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_pc_q    <= m_pc_d;
            m_inst_q  <= m_inst_d;
            s_valid_q <= s_valid_d;
            s_pc_q    <= s_pc_d;
            s_inst_q  <= s_inst_d;
        end
    end

    decode_fields #(
        .EXT_W(EXT_W)
    ) u_fields (
        .Inst     (m_inst_q),
        .OpCode   (OpCode),
        .Rs       (Rs),
        .Rt       (Rt),
        .Rd       (Rd),
        .Shamt    (Shamt),
        .Funct    (Funct),
        .Addr     (Addr),
        .Imm      (Imm),
        .ExtImm   (ExtImm),
        .InstClass(InstClass)
    );

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vectors plus random traffic vs. a queue model.
module tb_decode_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Flush;
    logic        InValid;
    logic        InReady;
    logic [31:0] InPC;
    logic [31:0] Inst;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutPC;
    logic [5:0]  OpCode;
    logic [4:0]  Rs, Rt, Rd;
    logic [4:0]  Shamt;
    logic [5:0]  Funct;
    logic [25:0] Addr;
    logic [15:0] Imm;
    logic [31:0] ExtImm;
    logic [1:0]  InstClass;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t model_q[$];

    always #5 Clk = ~Clk;

    decode_stage dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Flush    (Flush),
        .InValid  (InValid),
        .InReady  (InReady),
        .InPC     (InPC),
        .Inst     (Inst),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutPC    (OutPC),
        .OpCode   (OpCode),
        .Rs       (Rs),
        .Rt       (Rt),
        .Rd       (Rd),
        .Shamt    (Shamt),
        .Funct    (Funct),
        .Addr     (Addr),
        .Imm      (Imm),
        .ExtImm   (ExtImm),
        .InstClass(InstClass)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode written straight from the instruction-set rules.
    function automatic logic [31:0] ref_ext(input logic [31:0] w);
        int unsigned op  = w >> 26;
        int unsigned imm = w & 32'hFFFF;
        if (op >= 12 && op <= 14) return imm;
        if (op == 15)             return imm * 65536;
        if (imm >= 32768)         return imm + 32'hFFFF0000;
        return imm;
    endfunction

    function automatic logic [1:0] ref_class(input logic [31:0] w);
        int unsigned op = w >> 26;
        if (op == 0)            return 2'd0;
        if (op == 2 || op == 3) return 2'd2;
        return 2'd1;
    endfunction

    // Compare every DUT output with the model; fields only while an entry is held.
    task automatic check_outputs();
        entry_t e;
        check("out_valid", OutValid, model_q.size() > 0);
        check("in_ready", InReady, model_q.size() < 2);
        if (model_q.size() > 0) begin
            e = model_q[0];
            check("out_pc", OutPC, e.pc);
            check("opcode", OpCode, e.inst / 32'h0400_0000);
            check("rs", Rs, (e.inst / 32'h0020_0000) % 32);
            check("rt", Rt, (e.inst / 32'h0001_0000) % 32);
            check("rd", Rd, (e.inst / 32'h0000_0800) % 32);
            check("shamt", Shamt, (e.inst / 64) % 32);
            check("funct", Funct, e.inst % 64);
            check("addr", Addr, e.inst % 32'h0400_0000);
            check("imm", Imm, e.inst % 65536);
            check("ext_imm", ExtImm, ref_ext(e.inst));
            check("inst_class", InstClass, ref_class(e.inst));
        end
    endtask

    // One clock: check at negedge, drive, advance the model, cross the posedge.
    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] w,
                        input logic ordy, input logic fl);
        bit acc;
        bit pp;
        entry_t e;
        check_outputs();
        InValid  = iv;
        InPC     = pc;
        Inst     = w;
        OutReady = ordy;
        Flush    = fl;
        acc = iv && (model_q.size() < 2);
        pp  = ordy && (model_q.size() > 0);
        if (fl) begin
            model_q.delete();
        end else begin
            if (pp) void'(model_q.pop_front());
            if (acc) begin
                e.pc   = pc;
                e.inst = w;
                model_q.push_back(e);
            end
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Rst      = 1'b1;
        InValid  = 1'b0;
        OutReady = 1'b0;
        Flush    = 1'b0;
        InPC     = '0;
        Inst     = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        model_q.delete();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] ops [8];
        logic [5:0] op;
        ops = '{6'h00, 6'h02, 6'h03, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h08};
        op  = ops[$urandom_range(0, 7)];
        if ($urandom_range(0, 3) == 0) op = 6'($urandom);
        return {op, 26'($urandom)};
    endfunction

    initial begin
        do_reset();
        check("rst_out_valid", OutValid, 0);
        check("rst_in_ready", InReady, 1);
        check("rst_opcode", OpCode, 0);
        check("rst_ext_imm", ExtImm, 0);
        check("rst_class", InstClass, 0);
        check("rst_out_pc", OutPC, 0);

        // Streaming decode of the reference vectors.
        step(1, 32'h100, 32'h2008FFFF, 1, 0);
        check("addi_valid", OutValid, 1);
        check("addi_rs", Rs, 0);
        check("addi_rt", Rt, 8);
        check("addi_ext", ExtImm, 32'hFFFFFFFF);
        check("addi_class", InstClass, 1);
        check("addi_pc", OutPC, 32'h100);
        step(1, 32'h104, 32'h3508FFFF, 1, 0);
        check("ori_ext", ExtImm, 32'h0000FFFF);
        step(1, 32'h108, 32'h3C081234, 1, 0);
        check("lui_ext", ExtImm, 32'h12340000);
        step(1, 32'h10C, 32'h0C000010, 1, 0);
        check("jal_class", InstClass, 2);
        check("jal_addr", Addr, 26'h10);
        step(1, 32'h110, 32'h01095020, 1, 0);
        check("add_rd", Rd, 10);
        check("add_funct", Funct, 6'h20);
        check("add_class", InstClass, 0);
        step(0, 0, 0, 1, 0);
        check("drain_valid", OutValid, 0);

        // Back-pressure: A and B queue up, then drain in order.
        step(1, 32'h200, 32'h2009_0001, 0, 0);
        step(1, 32'h204, 32'h200A_0002, 0, 0);
        check("bp_in_ready", InReady, 0);
        check("bp_hold_pc", OutPC, 32'h200);
        step(1, 32'h208, 32'h200B_0003, 0, 0);
        check("bp_still_a", OutPC, 32'h200);
        step(0, 0, 0, 1, 0);
        check("bp_b_pc", OutPC, 32'h204);
        check("bp_ready_back", InReady, 1);
        step(0, 0, 0, 1, 0);
        check("bp_empty", OutValid, 0);

        // Flush with both slots full and a word offered.
        step(1, 32'h300, 32'h2001_0001, 0, 0);
        step(1, 32'h304, 32'h2002_0002, 0, 0);
        step(1, 32'h308, 32'h2003_0003, 0, 1);
        check("flush_valid", OutValid, 0);
        check("flush_ready", InReady, 1);
        // Flush beats accept even when the stage could accept.
        step(1, 32'h30C, 32'h2004_0004, 1, 1);
        check("flush_drop_in", OutValid, 0);
        step(1, 32'h310, 32'h2005_0005, 1, 0);
        check("post_flush_pc", OutPC, 32'h310);

        // Random traffic against the queue model.
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 9) < 7, $urandom, rand_inst(),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
        end

        // Reset mid-transfer drops everything.
        step(1, 32'h400, 32'h2006_0006, 0, 0);
        step(1, 32'h404, 32'h2007_0007, 0, 0);
        do_reset();
        check("rst2_valid", OutValid, 0);
        check("rst2_ready", InReady, 1);
        check("rst2_opcode", OpCode, 0);
        check("rst2_ext", ExtImm, 0);
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
